spu_ri16_decode: RTL

- Decodes 32-bit SPU RI16-format instruction words for the immediate-load halfword opcodes in `defines_pkg` (IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_HALFWORD_UPPER).
- Produces a 128-bit register-file write command.
- Sits between instruction issue and the register-file write port.
- Elastic pipeline of `NUM_PIPES` stages with valid/ready on both sides.

---
 rtl/spu_ri16_decode.sv | 104 ++++++++++
 1 files changed

// File: rtl/spu_ri16_decode.sv
// spu_ri16_decode: RI16 immediate-load-halfword decoder feeding a NUM_PIPES-stage elastic pipeline.
// Define SPU_ILLEGAL_CNT_EN to build the saturating illegal-opcode counter; otherwise illegal_cnt is 0.
package defines_pkg;
   localparam int NUM_PIPES = 2;
   typedef enum logic [10:0] {
      IMMEDIATE_LOAD_HALFWORD_UPPER = 11'h082,
      IMMEDIATE_LOAD_HALFWORD       = 11'h083
   } Opcodes;
endpackage

module spu_ri16_decode #(
   parameter int NUM_PIPES = defines_pkg::NUM_PIPES,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_wr_en,
   output logic [6:0]       out_rt,
   output logic [127:0]     out_wr_data,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   typedef struct packed {
      logic         wr_en;
      logic [6:0]   rt;
      logic [127:0] wr_data;
      logic         illegal;
   } cmd_t;

   logic [10:0]          opcode;
   logic [15:0]          i16;
   logic                 is_ilh;
   logic                 is_ilhu;
   logic                 rdy;
   cmd_t                 dec;
   logic [NUM_PIPES-1:0] stage_ready;
   logic [NUM_PIPES-1:0] valid_q, valid_d;
   cmd_t [NUM_PIPES-1:0] pay_q, pay_d;

   always_comb begin
      opcode      = {2'b00, in_instr[31:23]};
      i16         = in_instr[22:7];
      is_ilh      = opcode == defines_pkg::IMMEDIATE_LOAD_HALFWORD;
      is_ilhu     = opcode == defines_pkg::IMMEDIATE_LOAD_HALFWORD_UPPER;
      dec.wr_en   = is_ilh || is_ilhu;
      dec.rt      = in_instr[6:0];
      dec.wr_data = is_ilh ? {8{i16}} : is_ilhu ? {4{i16, 16'h0000}} : '0;
      dec.illegal = !(is_ilh || is_ilhu);
   end

   // A stage can load if it or any stage downstream of it is empty, or the sink is ready.
   always_comb begin
      rdy = out_ready;
      for (int i = NUM_PIPES - 1; i >= 0; i--) begin
         rdy            = rdy || !valid_q[i];
         stage_ready[i] = rdy;
      end
      valid_d[0] = stage_ready[0] ? in_valid : valid_q[0];
      pay_d[0]   = (stage_ready[0] && in_valid) ? dec : pay_q[0];
      for (int i = 1; i < NUM_PIPES; i++) begin
         valid_d[i] = stage_ready[i] ? valid_q[i-1] : valid_q[i];
         pay_d[i]   = (stage_ready[i] && valid_q[i-1]) ? pay_q[i-1] : pay_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         pay_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pay_q   <= pay_d;
      end
   end

   assign in_ready    = stage_ready[0];
   assign out_valid   = valid_q[NUM_PIPES-1];
   assign out_wr_en   = pay_q[NUM_PIPES-1].wr_en;
   assign out_rt      = pay_q[NUM_PIPES-1].rt;
   assign out_wr_data = pay_q[NUM_PIPES-1].wr_data;
   assign out_illegal = pay_q[NUM_PIPES-1].illegal;

`ifdef SPU_ILLEGAL_CNT_EN
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   always_comb
      illegal_cnt_d = (in_valid && in_ready && dec.illegal && illegal_cnt_q != '1) ?
                      illegal_cnt_q + 1'b1 : illegal_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_cnt_q <= '0;
      else        illegal_cnt_q <= illegal_cnt_d;
   end

   assign illegal_cnt = illegal_cnt_q;
`else
   assign illegal_cnt = '0;
`endif
endmodule
